// File: rtl/score_pkg.sv
// Shared types and helpers for the score_bank quiz score keeper.
package score_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

    localparam int DEFAULT_CORRECT_PTS = 10;
    localparam int DEFAULT_WRONG_PTS   = 5;

    // Index width for n items; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/score_bank_rise_detect.sv
// One-bit registered rising-edge detector for a level button input.
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic rise_o
);

    logic prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= d_i;
        end
    end

    assign rise_o = d_i & ~prev_q;

endmodule

// File: rtl/score_bank.sv
// Saturating per-player score bank with sequential leader scan.
// Optional one-level undo is built when SCORE_UNDO_EN is defined.
module score_bank
    import score_pkg::*;
#(
    parameter int NUM_PLAYERS = 4,
    parameter int SCORE_W     = 8,
    parameter int CORRECT_PTS = DEFAULT_CORRECT_PTS,
    parameter int WRONG_PTS   = DEFAULT_WRONG_PTS
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           enable,
    input  logic                           clear,
    input  logic [NUM_PLAYERS-1:0]         player,
    input  logic                           ifCorrect,
    input  logic                           ifWrong,
`ifdef SCORE_UNDO_EN
    input  logic                           undo,
`endif
    output logic [NUM_PLAYERS*SCORE_W-1:0] scores,
    output logic [NUM_PLAYERS-1:0]         leader,
    output logic                           leader_valid,
    output logic                           upd,
    output logic                           err
);

    localparam int                 IDX_W       = idx_w(NUM_PLAYERS);
    localparam logic [IDX_W-1:0]   LAST_IDX    = IDX_W'(NUM_PLAYERS - 1);
    localparam logic [SCORE_W:0]   CORRECT_EXT = (SCORE_W+1)'(CORRECT_PTS);
    localparam logic [SCORE_W:0]   WRONG_EXT   = (SCORE_W+1)'(WRONG_PTS);
    localparam logic [SCORE_W-1:0] SCORE_MAX   = '1;

    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                   input logic [SCORE_W:0]   b);
        logic [SCORE_W:0] s;
        s = {1'b0, a} + b;
        return s[SCORE_W] ? SCORE_MAX : s[SCORE_W-1:0];
    endfunction

    function automatic logic [SCORE_W-1:0] sat_sub(input logic [SCORE_W-1:0] a,
                                                   input logic [SCORE_W:0]   b);
        logic [SCORE_W:0] s;
        s = {1'b0, a} - b;
        return s[SCORE_W] ? '0 : s[SCORE_W-1:0];
    endfunction

    logic rise_correct;
    logic rise_wrong;

    rise_detect u_rise_correct (
        .clk    (clk),
        .rst    (rst),
        .d_i    (ifCorrect),
        .rise_o (rise_correct)
    );

    rise_detect u_rise_wrong (
        .clk    (clk),
        .rst    (rst),
        .d_i    (ifWrong),
        .rise_o (rise_wrong)
    );

`ifdef SCORE_UNDO_EN
    logic rise_undo;

    rise_detect u_rise_undo (
        .clk    (clk),
        .rst    (rst),
        .d_i    (undo),
        .rise_o (rise_undo)
    );

    // Reverse an applied delta; the clamp only guards against impossible history.
    function automatic logic [SCORE_W-1:0] undo_apply(input logic [SCORE_W-1:0]      a,
                                                      input logic signed [SCORE_W:0] d);
        logic [SCORE_W+1:0] t;
        t = {2'b00, a} - {d[SCORE_W], d};
        if (t[SCORE_W+1]) begin
            return '0;
        end else if (t[SCORE_W]) begin
            return SCORE_MAX;
        end
        return t[SCORE_W-1:0];
    endfunction

    logic [IDX_W-1:0]        hist_idx_q, hist_idx_d;
    logic signed [SCORE_W:0] hist_delta_q, hist_delta_d;
    logic                    hist_vld_q, hist_vld_d;
`endif

    logic [SCORE_W-1:0] score_q [NUM_PLAYERS];
    logic [SCORE_W-1:0] score_d [NUM_PLAYERS];
    logic               upd_q, upd_d;
    logic               err_q, err_d;

    logic               player_onehot;
    logic [IDX_W-1:0]   player_idx;
    logic               verdict;
    logic               accept;
    logic               changed;
    logic [SCORE_W-1:0] cur_score;
    logic [SCORE_W-1:0] nxt_score;

    always_comb begin
        player_onehot = (player != '0) && ((player & (player - 1'b1)) == '0);
        player_idx    = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (player[i]) begin
                player_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            score_d[i] = score_q[i];
        end
        err_d     = 1'b0;
        changed   = 1'b0;
        verdict   = enable & (rise_correct | rise_wrong);
        accept    = verdict & player_onehot & (rise_correct ^ rise_wrong);
        cur_score = score_q[player_idx];
        nxt_score = rise_correct ? sat_add(cur_score, CORRECT_EXT)
                                 : sat_sub(cur_score, WRONG_EXT);
`ifdef SCORE_UNDO_EN
        hist_idx_d   = hist_idx_q;
        hist_delta_d = hist_delta_q;
        hist_vld_d   = hist_vld_q;
`endif

        if (clear) begin
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                score_d[i] = '0;
            end
`ifdef SCORE_UNDO_EN
            hist_vld_d = 1'b0;
`endif
        end else if (accept) begin
            score_d[player_idx] = nxt_score;
            changed             = (nxt_score != cur_score);
`ifdef SCORE_UNDO_EN
            // Saturated no-ops are still recorded, with a zero delta.
            hist_idx_d   = player_idx;
            hist_delta_d = $signed({1'b0, nxt_score}) - $signed({1'b0, cur_score});
            hist_vld_d   = 1'b1;
`endif
        end else if (verdict) begin
            err_d = 1'b1;
        end
`ifdef SCORE_UNDO_EN
        else if (enable && rise_undo && hist_vld_q) begin
            score_d[hist_idx_q] = undo_apply(score_q[hist_idx_q], hist_delta_q);
            changed             = (score_d[hist_idx_q] != score_q[hist_idx_q]);
            hist_vld_d          = 1'b0;
        end
`endif

        upd_d = changed;
    end

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      scan_idx_q, scan_idx_d;
    logic [SCORE_W-1:0]    max_q, max_d;
    logic [IDX_W-1:0]      max_idx_q, max_idx_d;
    logic [NUM_PLAYERS-1:0] leader_q, leader_d;
    logic                  scan_last;
    logic [SCORE_W-1:0]    cand;
    logic                  cand_gt;
    logic [SCORE_W-1:0]    best;
    logic [IDX_W-1:0]      best_idx;

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else if (changed) begin
            state_d = SCAN;
        end else if (scan_last) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        leader_valid = (state_q == IDLE);
        scan_last    = (state_q == SCAN) && (scan_idx_q == LAST_IDX);
    end

    // Running max; strict compare keeps ties on the lowest index.
    always_comb begin
        scan_idx_d = scan_idx_q;
        max_d      = max_q;
        max_idx_d  = max_idx_q;
        leader_d   = leader_q;
        cand       = score_q[scan_idx_q];
        cand_gt    = (cand > max_q);
        best       = cand_gt ? cand : max_q;
        best_idx   = cand_gt ? scan_idx_q : max_idx_q;

        if (clear) begin
            leader_d   = '0;
            scan_idx_d = '0;
            max_d      = '0;
            max_idx_d  = '0;
        end else if (changed) begin
            scan_idx_d = '0;
            max_d      = '0;
            max_idx_d  = '0;
        end else if (state_q == SCAN) begin
            if (scan_last) begin
                leader_d   = (best == '0) ? '0 : (NUM_PLAYERS'(1) << best_idx);
                scan_idx_d = '0;
            end else begin
                scan_idx_d = scan_idx_q + 1'b1;
                max_d      = best;
                max_idx_d  = best_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                score_q[i] <= '0;
            end
            upd_q      <= 1'b0;
            err_q      <= 1'b0;
            state_q    <= IDLE;
            scan_idx_q <= '0;
            max_q      <= '0;
            max_idx_q  <= '0;
            leader_q   <= '0;
`ifdef SCORE_UNDO_EN
            hist_idx_q   <= '0;
            hist_delta_q <= '0;
            hist_vld_q   <= 1'b0;
`endif
        end else begin
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                score_q[i] <= score_d[i];
            end
            upd_q      <= upd_d;
            err_q      <= err_d;
            state_q    <= state_d;
            scan_idx_q <= scan_idx_d;
            max_q      <= max_d;
            max_idx_q  <= max_idx_d;
            leader_q   <= leader_d;
`ifdef SCORE_UNDO_EN
            hist_idx_q   <= hist_idx_d;
            hist_delta_q <= hist_delta_d;
            hist_vld_q   <= hist_vld_d;
`endif
        end
    end

    for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_pack
        assign scores[g*SCORE_W +: SCORE_W] = score_q[g];
    end

    assign leader = leader_q;
    assign upd    = upd_q;
    assign err    = err_q;

endmodule

// File: tb/tb_score_bank.sv
// Directed bench for score_bank at default parameters; undo steps build with SCORE_UNDO_EN.
module tb_score_bank;

    localparam int NP = 4;
    localparam int SW = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              enable;
    logic              clear;
    logic [NP-1:0]     player;
    logic              ifCorrect;
    logic              ifWrong;
`ifdef SCORE_UNDO_EN
    logic              undo;
`endif
    logic [NP*SW-1:0]  scores;
    logic [NP-1:0]     leader;
    logic              leader_valid;
    logic              upd;
    logic              err;

    int tests  = 0;
    int failed = 0;
    logic [SW-1:0] p3_exp;

    always #5 clk = ~clk;

    score_bank #(
        .NUM_PLAYERS (NP),
        .SCORE_W     (SW),
        .CORRECT_PTS (10),
        .WRONG_PTS   (5)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .clear        (clear),
        .player       (player),
        .ifCorrect    (ifCorrect),
        .ifWrong      (ifWrong),
`ifdef SCORE_UNDO_EN
        .undo         (undo),
`endif
        .scores       (scores),
        .leader       (leader),
        .leader_valid (leader_valid),
        .upd          (upd),
        .err          (err)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [SW-1:0] sc(input int i);
        return scores[i*SW +: SW];
    endfunction

    task automatic press_c(input logic [NP-1:0] p);
        player    = p;
        ifCorrect = 1'b1;
        step(1);
        ifCorrect = 1'b0;
    endtask

    task automatic press_w(input logic [NP-1:0] p);
        player  = p;
        ifWrong = 1'b1;
        step(1);
        ifWrong = 1'b0;
    endtask

`ifdef SCORE_UNDO_EN
    task automatic press_u();
        undo = 1'b1;
        step(1);
        undo = 1'b0;
    endtask
`endif

    initial begin
        rst = 1'b1; enable = 1'b1; clear = 1'b0; player = '0;
        ifCorrect = 1'b0; ifWrong = 1'b0;
`ifdef SCORE_UNDO_EN
        undo = 1'b0;
`endif
        step(2);
        chk("rst_scores", scores, 32'h0);
        chk("rst_leader", leader, 4'b0000);
        chk("rst_lv", leader_valid, 1'b1);
        chk("rst_upd", upd, 1'b0);
        chk("rst_err", err, 1'b0);
        rst = 1'b0;
        step(1);

        // First correct on P1: score at t+1, leader valid at t+5.
        press_c(4'b0010);
        chk("c1_score", sc(1), 8'd10);
        chk("c1_upd", upd, 1'b1);
        chk("c1_lv_drop", leader_valid, 1'b0);
        step(1);
        chk("c1_upd_end", upd, 1'b0);
        step(2);
        chk("c1_lv_t4", leader_valid, 1'b0);
        step(1);
        chk("c1_lv_t5", leader_valid, 1'b1);
        chk("c1_leader", leader, 4'b0010);

        // Wrong on P0 at zero saturates silently.
        press_w(4'b0001);
        chk("w0_score", sc(0), 8'd0);
        chk("w0_upd", upd, 1'b0);
        chk("w0_lv", leader_valid, 1'b1);
        step(1);
`ifdef SCORE_UNDO_EN
        press_u();
        chk("u0_score", sc(0), 8'd0);
        chk("u0_upd", upd, 1'b0);
        chk("u0_err", err, 1'b0);
        step(1);
`endif

        // Climb P3 to 250, then saturate at 255.
        for (int k = 0; k < 25; k++) begin
            press_c(4'b1000);
            step(1);
        end
        chk("p3_250", sc(3), 8'd250);
        press_c(4'b1000);
        chk("p3_sat", sc(3), 8'd255);
        chk("p3_sat_upd", upd, 1'b1);
        step(1);
        p3_exp = 8'd255;
`ifdef SCORE_UNDO_EN
        press_u();
        chk("p3_undo", sc(3), 8'd250);
        chk("p3_undo_upd", upd, 1'b1);
        step(1);
        p3_exp = 8'd250;
`endif
        step(6);
        chk("p3_leader", leader, 4'b1000);
        chk("p3_lv", leader_valid, 1'b1);
        chk("p3_final", sc(3), p3_exp);

        // Rejected verdicts: multi-hot player, then both buttons at once.
        player = 4'b0110; ifCorrect = 1'b1;
        step(1);
        chk("mh_err", err, 1'b1);
        chk("mh_upd", upd, 1'b0);
        chk("mh_p1", sc(1), 8'd10);
        chk("mh_p2", sc(2), 8'd0);
        ifCorrect = 1'b0;
        step(1);
        chk("mh_err_end", err, 1'b0);
        player = 4'b0001; ifCorrect = 1'b1; ifWrong = 1'b1;
        step(1);
        chk("both_err", err, 1'b1);
        chk("both_p0", sc(0), 8'd0);
        ifCorrect = 1'b0; ifWrong = 1'b0;
        step(1);
        enable = 1'b0;
        press_c(4'b0001);
        chk("dis_err", err, 1'b0);
        chk("dis_upd", upd, 1'b0);
        chk("dis_p0", sc(0), 8'd0);
        enable = 1'b1;
        step(1);

        // Back-to-back: correct edge then wrong edge on consecutive cycles.
        player = 4'b0001; ifCorrect = 1'b1;
        step(1);
        chk("b2b_first", sc(0), 8'd10);
        ifWrong = 1'b1;
        step(1);
        chk("b2b_second", sc(0), 8'd5);
        chk("b2b_upd", upd, 1'b1);
        ifCorrect = 1'b0; ifWrong = 1'b0;
        step(1);
        chk("b2b_hold", sc(0), 8'd5);

        // Reset in the middle of a scan.
        press_c(4'b0010);
        step(1);
        rst = 1'b1;
        step(1);
        chk("mrst_scores", scores, 32'h0);
        chk("mrst_lv", leader_valid, 1'b1);
        chk("mrst_leader", leader, 4'b0000);
        rst = 1'b0;
        step(1);

        // Tie between P1 and P2 at 20 resolves to P1.
        press_c(4'b0010); step(1);
        press_c(4'b0010); step(1);
        press_c(4'b0100); step(1);
        press_c(4'b0100);
        step(6);
        chk("tie_p1", sc(1), 8'd20);
        chk("tie_p2", sc(2), 8'd20);
        chk("tie_leader", leader, 4'b0010);
        chk("tie_lv", leader_valid, 1'b1);

        // A new event two cycles into the scan restarts it.
        press_c(4'b0100);
        step(2);
        player = 4'b0001; ifCorrect = 1'b1;
        step(1);
        ifCorrect = 1'b0;
        step(3);
        chk("rs_lv_low", leader_valid, 1'b0);
        step(1);
        chk("rs_lv_high", leader_valid, 1'b1);
        chk("rs_leader", leader, 4'b0100);
        chk("rs_p0", sc(0), 8'd10);

        // Held button yields a single event.
        player = 4'b0010; ifCorrect = 1'b1;
        step(10);
        ifCorrect = 1'b0;
        chk("hold_p1", sc(1), 8'd30);
        step(1);

        clear = 1'b1;
        step(1);
        clear = 1'b0;
        chk("clr_scores", scores, 32'h0);
        chk("clr_leader", leader, 4'b0000);
        chk("clr_lv", leader_valid, 1'b1);
        chk("clr_upd", upd, 1'b0);
        chk("clr_err", err, 1'b0);
        step(1);
`ifdef SCORE_UNDO_EN
        press_u();
        chk("clr_undo_upd", upd, 1'b0);
        chk("clr_undo_scores", scores, 32'h0);
        step(1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
